// File: rtl/dig_ct_driver.sv
// Stimulus sequencer for the DigCt logic block: sweeps all 32 input vectors,
// compares the block's outputs against expected values after LAT cycles.
module dig_ct_driver #(
    parameter int unsigned LAT   = 2,
    parameter int unsigned ERR_W = 6
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    output logic             DRV1,
    output logic             DRV2,
    output logic             DRV3,
    output logic             DRV4,
    output logic             DRV5,
    input  logic             OBS1,
    input  logic             OBS2,
    input  logic             OBS3,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [ERR_W-1:0] ERR_CNT,
    output logic             FIRST_ERR_VLD,
    output logic [4:0]       FIRST_ERR_VEC
);

    localparam int unsigned VEC_W = 5;
    localparam int unsigned EXP_W = 3;
    localparam int unsigned ENT_W = 1 + VEC_W + EXP_W;
    localparam int unsigned DRN_W = 3;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;

    localparam logic [ERR_W-1:0] ERR_MAX  = '1;
    localparam logic [VEC_W-1:0] VEC_LAST = 5'd31;
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(LAT - 1);

    // Expected DigCt outputs packed as {E1, E2, E3}
    function automatic logic [EXP_W-1:0] exp_f(input logic [VEC_W-1:0] v);
        exp_f = {v[0] | v[1] | ~v[2], ~(v[1] & v[2]), v[1] | v[2] | v[4]};
    endfunction

    logic [1:0]       state_q, state_d;
    logic [VEC_W-1:0] cnt_q, cnt_d;
    logic [VEC_W-1:0] drv_q, drv_d;
    logic [DRN_W-1:0] drn_q, drn_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             fvld_q, fvld_d;
    logic [VEC_W-1:0] fvec_q, fvec_d;

    logic             ld_c;
    logic [ENT_W-1:0] pipe_in_c;
    logic [ENT_W-1:0] tail_c;
    logic             mism_c;
    logic [ENT_W-1:0] pipe_q [LAT];

    assign tail_c = pipe_q[LAT-1];
    assign mism_c = tail_c[ENT_W-1] && ({OBS1, OBS2, OBS3} != tail_c[EXP_W-1:0]);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drv_d   = drv_q;
        drn_d   = drn_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        err_d   = err_q;
        fvld_d  = fvld_q;
        fvec_d  = fvec_q;
        ld_c    = 1'b0;

        if (mism_c) begin
            err_d = (err_q == ERR_MAX) ? err_q : ERR_W'(err_q + 1'b1);
            if (!fvld_q) begin
                fvld_d = 1'b1;
                fvec_d = tail_c[ENT_W-2:EXP_W];
            end
        end

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    err_d   = '0;
                    fvld_d  = 1'b0;
                    fvec_d  = '0;
                    pass_d  = 1'b0;
                    drv_d   = '0;
                    cnt_d   = 5'd1;
                    ld_c    = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                drv_d = cnt_q;
                cnt_d = VEC_W'(cnt_q + 1'b1);
                ld_c  = 1'b1;
                if (cnt_q == VEC_LAST) begin
                    drn_d   = '0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drn_q == DRN_LAST) begin
                    state_d = S_FIN;
                end else begin
                    drn_d = DRN_W'(drn_q + 1'b1);
                end
            end
            default: begin
                done_d  = 1'b1;
                pass_d  = (err_q == '0);
                state_d = S_IDLE;
            end
        endcase

        busy_d    = (state_d == S_RUN) || (state_d == S_DRAIN);
        pipe_in_c = {ld_c, drv_d, exp_f(drv_d)};
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            drv_q   <= '0;
            drn_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fvld_q  <= 1'b0;
            fvec_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drv_q   <= drv_d;
            drn_q   <= drn_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fvld_q  <= fvld_d;
            fvec_q  <= fvec_d;
        end
    end

    // Expected/valid pipeline aligning each vector with its compare edge
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= pipe_in_c;
            for (int i = 1; i < LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign DRV1          = drv_q[0];
    assign DRV2          = drv_q[1];
    assign DRV3          = drv_q[2];
    assign DRV4          = drv_q[3];
    assign DRV5          = drv_q[4];
    assign BUSY          = busy_q;
    assign DONE          = done_q;
    assign PASS          = pass_q;
    assign ERR_CNT       = err_q;
    assign FIRST_ERR_VLD = fvld_q;
    assign FIRST_ERR_VEC = fvec_q;

endmodule

// File: tb/tb_dig_ct_driver.sv
// Bench for dig_ct_driver: three instances (LAT/ERR_W variants) each driving
// a golden DigCt model with optional stuck-at faults on its outputs.
module tb_dig_ct_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [2:0]      start_r;
    int              fault_mode [3];
    logic [2:0][4:0] drv_w;
    logic [2:0]      busy_w;
    logic [2:0]      done_w;
    logic [2:0]      pass_w;
    logic [2:0]      fvld_w;
    logic [2:0][7:0] err_w;
    logic [2:0][4:0] fvec_w;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int err;
        int fvld;
        int fvec;
        int pass;
    } res_t;
    res_t sb [$];

    // Golden DigCt function, {OUT1, OUT2, OUT3}
    function automatic logic [2:0] golden(input logic [4:0] v);
        logic e1, e2, e3;
        e1 = !(v[2] && !v[0] && !v[1]);
        e2 = !v[1] || !v[2];
        e3 = (v & 5'b10110) != 5'b00000;
        return {e1, e2, e3};
    endfunction

    // 1: OUT2 stuck at 1, 2: OUT3 stuck at 0, 3: OUT1 stuck at 0
    function automatic logic [2:0] faulty(input logic [2:0] g, input int f);
        logic [2:0] r;
        r = g;
        case (f)
            1: r[1] = 1'b1;
            2: r[0] = 1'b0;
            3: r[2] = 1'b0;
            default: ;
        endcase
        return r;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned LATG = (g == 2) ? 1 : 2;
        localparam int unsigned EWG  = (g == 1) ? 3 : 6;
        logic [4:0]     drv;
        logic [EWG-1:0] ec;
        logic [2:0]     obs_reg;
        logic [2:0]     obs_raw;
        logic [2:0]     obs;

        always_ff @(posedge clk) obs_reg <= golden(drv);
        assign obs_raw = (LATG == 1) ? golden(drv) : obs_reg;
        assign obs     = faulty(obs_raw, fault_mode[g]);

        dig_ct_driver #(.LAT(LATG), .ERR_W(EWG)) u_dut (
            .CLK          (clk),
            .RST_N        (rst_n),
            .START        (start_r[g]),
            .DRV1         (drv[0]),
            .DRV2         (drv[1]),
            .DRV3         (drv[2]),
            .DRV4         (drv[3]),
            .DRV5         (drv[4]),
            .OBS1         (obs[2]),
            .OBS2         (obs[1]),
            .OBS3         (obs[0]),
            .BUSY         (busy_w[g]),
            .DONE         (done_w[g]),
            .PASS         (pass_w[g]),
            .ERR_CNT      (ec),
            .FIRST_ERR_VLD(fvld_w[g]),
            .FIRST_ERR_VEC(fvec_w[g])
        );

        assign drv_w[g] = drv;
        assign err_w[g] = 8'(ec);
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle_zero(input int s, input string tag);
        check_eq({tag, "_drv"},  int'(drv_w[s]),  0);
        check_eq({tag, "_busy"}, int'(busy_w[s]), 0);
        check_eq({tag, "_done"}, int'(done_w[s]), 0);
        check_eq({tag, "_pass"}, int'(pass_w[s]), 0);
        check_eq({tag, "_err"},  int'(err_w[s]),  0);
        check_eq({tag, "_fvld"}, int'(fvld_w[s]), 0);
        check_eq({tag, "_fvec"}, int'(fvec_w[s]), 0);
    endtask

    task automatic run_sweep(input int s, input int f, input bit repulse);
        int   lat;
        int   ew;
        int   errs;
        int   first;
        bit   seen;
        res_t r;
        res_t e;
        lat   = (s == 2) ? 1 : 2;
        ew    = (s == 1) ? 3 : 6;
        errs  = 0;
        first = -1;
        seen  = 1'b0;
        fault_mode[s] = f;
        for (int v = 0; v < 32; v++) begin
            if (faulty(golden(5'(v)), f) != golden(5'(v))) begin
                errs++;
                if (first < 0) first = v;
            end
        end
        r.err  = (errs > (1 << ew) - 1) ? (1 << ew) - 1 : errs;
        r.fvld = (first >= 0) ? 1 : 0;
        r.fvec = (first >= 0) ? first : 0;
        r.pass = (errs == 0) ? 1 : 0;
        sb.push_back(r);

        @(negedge clk);
        start_r[s] = 1'b1;
        @(negedge clk);
        start_r[s] = 1'b0;
        check_eq("drv_v0", int'(drv_w[s]), 0);
        check_eq("busy_run", int'(busy_w[s]), 1);
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (k <= 31) begin
                check_eq("drv_seq", int'(drv_w[s]), k);
            end else if (k < 32 + lat) begin
                check_eq("drv_hold", int'(drv_w[s]), 31);
            end
            if (done_w[s]) begin
                seen = 1'b1;
                e = sb.pop_front();
                check_eq("done_time", k, 32 + lat);
                check_eq("busy_end", int'(busy_w[s]), 0);
                check_eq("err_cnt", int'(err_w[s]), e.err);
                check_eq("first_vld", int'(fvld_w[s]), e.fvld);
                check_eq("first_vec", int'(fvec_w[s]), e.fvec);
                check_eq("pass", int'(pass_w[s]), e.pass);
                break;
            end
            if (repulse && k == 9) start_r[s] = 1'b1;
            if (repulse && k == 10) start_r[s] = 1'b0;
        end
        if (!seen) begin
            check_eq("done_timeout", 0, 1);
            void'(sb.pop_front());
        end
        @(negedge clk);
        check_eq("done_pulse", int'(done_w[s]), 0);
        check_eq("err_hold", int'(err_w[s]), r.err);
        check_eq("pass_hold", int'(pass_w[s]), r.pass);
    endtask

    task automatic reset_abort();
        bit hit;
        int dones;
        hit   = 1'b0;
        dones = 0;
        fault_mode[0] = 2;
        @(negedge clk);
        start_r[0] = 1'b1;
        @(negedge clk);
        start_r[0] = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (drv_w[0] == 5'd12) begin
                hit = 1'b1;
                break;
            end
        end
        check_eq("reach_v12", int'(hit), 1);
        check_eq("pre_rst_err_nz", int'(err_w[0] != 8'd0), 1);
        rst_n = 1'b0;
        #1;
        check_idle_zero(0, "async_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done_w[0]) dones++;
        end
        check_eq("no_done_after_abort", dones, 0);
        check_eq("idle_after_abort", int'(busy_w[0]), 0);
    endtask

    initial begin
        rst_n   = 1'b0;
        start_r = '0;
        for (int i = 0; i < 3; i++) fault_mode[i] = 0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) check_idle_zero(i, "reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_sweep(0, 0, 1'b0);
        run_sweep(0, 1, 1'b0);
        run_sweep(0, 2, 1'b0);
        run_sweep(1, 3, 1'b0);
        reset_abort();
        run_sweep(0, 0, 1'b0);
        run_sweep(0, 0, 1'b1);
        run_sweep(2, 0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
